fetch_decode_queue: RTL

// - Receiving end of the IF-stage fetch interface: captures the (pc, insn) pairs produced by
//   the PC register + synchronous insnMem and buffers them in a small FIFO toward decode.
// - Drives PC back-pressure (wrEnable) and redirect (jump_enable/jump_address) into IF.
// - Flushes buffered and in-flight fetches on redirect.

---
 rtl/fetch_decode_queue_if.sv | 32 +++
 rtl/fetch_decode_queue.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue bus: IF-stage fetch inputs, PC control outputs, redirect and decode handshake.
// The slave modport is the queue side; the master modport is the surrounding pipeline.
interface fetch_decode_queue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INSN_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] if_pc;
    logic [INSN_W-1:0] if_insn;
    logic              pc_wr_en;
    logic              jump_enable;
    logic [ADDR_W-1:0] jump_address;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INSN_W-1:0] id_insn;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        output if_pc, if_insn, redirect_valid, redirect_addr, id_ready,
        input  pc_wr_en, jump_enable, jump_address, id_valid, id_pc, id_insn, occupancy
    );

    modport slave (
        input  if_pc, if_insn, redirect_valid, redirect_addr, id_ready,
        output pc_wr_en, jump_enable, jump_address, id_valid, id_pc, id_insn, occupancy
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode queue: captures (pc, insn) one cycle after issue, buffers toward decode,
// throttles the PC and flushes on redirect. Optional same-cycle bypass: FETCH_BYPASS_EN.
module fetch_decode_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INSN_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input logic                  clk,
    input logic                  rst,
    fetch_decode_queue_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0]    FILL_MAX = (CNT_W + 1)'(DEPTH);
    localparam logic [INSN_W-1:0] NOP      = INSN_W'(32'h0000_0013);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              inflight_v_q, inflight_v_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
    logic [INSN_W-1:0] mem_insn_q [DEPTH];

    logic [CNT_W:0] fill;
    logic           not_empty;
    logic           bypass;
    logic           issue;
    logic           capture;
    logic           pop;

    always_comb begin
        not_empty = (count_q != '0);
`ifdef FETCH_BYPASS_EN
        bypass = ~not_empty & inflight_v_q & ~bus.redirect_valid;
`else
        bypass = 1'b0;
`endif
        // Credit counts the in-flight fetch but never a same-cycle pop, so capture cannot overflow.
        fill         = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_v_q};
        bus.pc_wr_en = bus.redirect_valid | (fill < FILL_MAX);

        bus.jump_enable  = bus.redirect_valid;
        bus.jump_address = bus.redirect_addr;
        bus.occupancy    = count_q;
        bus.id_valid     = not_empty | bypass;
        if (not_empty) begin
            bus.id_pc   = mem_pc_q[head_q];
            bus.id_insn = mem_insn_q[head_q];
        end else if (bypass) begin
            bus.id_pc   = inflight_pc_q;
            bus.id_insn = bus.if_insn;
        end else begin
            bus.id_pc   = '0;
            bus.id_insn = NOP;
        end

        issue   = bus.pc_wr_en & ~bus.redirect_valid;
        pop     = not_empty & bus.id_ready;
        capture = inflight_v_q & ~bus.redirect_valid & ~(bypass & bus.id_ready);
    end

    always_comb begin
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        inflight_v_d  = issue;
        inflight_pc_d = issue ? bus.if_pc : inflight_pc_q;
        if (bus.redirect_valid) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (capture) tail_d = tail_q + PTR_W'(1);
            if (pop)     head_d = head_q + PTR_W'(1);
            unique case ({capture, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_pc_q[tail_q]   <= inflight_pc_q;
            mem_insn_q[tail_q] <= bus.if_insn;
        end
    end
endmodule
